// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths and control codes
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1101;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0111;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU with zero flag
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Decode the control code; unknown codes yield 0 so zero reads 1
    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $signed(a) >>> b[4:0];
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - pointer-based rotating grant with encoded index
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic [IDX_W-1:0]   next_ptr
);

    // Scan from ptr upward with wrap; the first asserted request wins
    always_comb begin
        int          j;
        logic [IDX_W-1:0] jj;
        logic        found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = IDX_W'(j);
            if (!found && req[jj]) begin
                found     = 1'b1;
                grant[jj] = 1'b1;
                idx       = jj;
            end
        end
    end

    // The pointer moves just past the winner only when the grant is taken
    always_comb begin
        next_ptr = ptr;
        if (advance) begin
            next_ptr = (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - one ALU shared by NUM_REQ requesters; ALU_ARB_RR_EN selects round-robin over fixed priority
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
    input  logic [NUM_REQ-1:0]        rsp_ready
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic              out_vld;
    logic [IDX_W-1:0]  out_id;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  next_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              out_free;
    logic              accept;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [CTRL_W-1:0] sel_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    assign out_free  = !out_vld || rsp_ready[out_id];
    assign req_ready = (rst_n && out_free) ? grant : '0;
    assign accept    = |req_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr),
        .advance  (accept),
        .grant    (grant),
        .idx      (grant_idx),
        .next_ptr (next_ptr)
    );

`ifdef ALU_ARB_RR_EN
    // Rotate the search start past each accepted requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= next_ptr;
        end
    end
`else
    logic [IDX_W-1:0] unused_next_ptr;
    assign ptr             = '0;
    assign unused_next_ptr = next_ptr;
`endif

    // Route the granted requester's operands into the shared ALU
    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_a    = req_a[i*DATA_W +: DATA_W];
                sel_b    = req_b[i*DATA_W +: DATA_W];
                sel_ctrl = req_ctrl[i*CTRL_W +: CTRL_W];
            end
        end
    end

    alu u_alu (
        .a      (sel_a),
        .b      (sel_b),
        .ctrl   (sel_ctrl),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Output register: reload on accept, otherwise retire on consume, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld    <= 1'b0;
            out_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else if (accept) begin
            out_vld    <= 1'b1;
            out_id     <= grant_idx;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
        end else if (out_vld && rsp_ready[out_id]) begin
            out_vld    <= 1'b0;
        end
    end

    // Expand the owner id into the one-hot response valid
    always_comb begin
        rsp_valid = '0;
        if (out_vld) rsp_valid[out_id] = 1'b1;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_ctrl;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [1:0]  rsp_ready;

    int checks = 0;
    int errors = 0;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    alu_share_arbiter #(.NUM_REQ(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        req_a = '0; req_b = '0; req_ctrl = '0;
        rsp_ready = 2'b11;
        #2;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
        checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_rsp_result got %h exp 0", rsp_result); end
        checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp_zero got %b exp 0", rsp_zero); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        req_valid = 2'b01;
        req_ctrl[3:0] = 4'b0000;
        req_a[31:0] = 32'd5;
        req_b[31:0] = 32'd7;
        rsp_ready = 2'b11;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready got %b exp 01", req_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b exp 01", rsp_valid); end
        checks++; if (rsp_result !== 32'd12) begin errors++; $display("FAIL single_rsp_result got %h exp c", rsp_result); end
        checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL single_rsp_zero got %b exp 0", rsp_zero); end
        req_valid = 2'b00;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_req_ready got %b exp 00", req_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL consume_rsp_valid got %b exp 00", rsp_valid); end
        checks++; if (rsp_result !== 32'd12) begin errors++; $display("FAIL consume_hold_result got %h exp c", rsp_result); end
    endtask

    task automatic test_both();
        logic [1:0]  exp_ready;
        logic [31:0] exp_res;
        logic        exp_zero;
        do_reset();
        req_ctrl = {4'b0110, 4'b1000};
        req_a = {32'h0000_00F0, 32'd9};
        req_b = {32'h0000_000F, 32'd9};
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_ready = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
            exp_res   = (exp_ready == 2'b10) ? 32'h0000_00FF : 32'h0;
            exp_zero  = (exp_ready == 2'b01);
            @(negedge clk);
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL both_req_ready[%0d] got %b exp %b", i, req_ready, exp_ready); end
            @(posedge clk); #1;
            checks++; if (rsp_valid !== exp_ready) begin errors++; $display("FAIL both_rsp_valid[%0d] got %b exp %b", i, rsp_valid, exp_ready); end
            checks++; if (rsp_result !== exp_res) begin errors++; $display("FAIL both_rsp_result[%0d] got %h exp %h", i, rsp_result, exp_res); end
            checks++; if (rsp_zero !== exp_zero) begin errors++; $display("FAIL both_rsp_zero[%0d] got %b exp %b", i, rsp_zero, exp_zero); end
        end
        req_valid = 2'b10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL both_drop0_req_ready got %b exp 10", req_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL both_drop0_rsp_valid got %b exp 10", rsp_valid); end
        checks++; if (rsp_result !== 32'h0000_00FF) begin errors++; $display("FAIL both_drop0_result got %h exp ff", rsp_result); end
        req_valid = 2'b00;
    endtask

    task automatic test_back_pressure();
        do_reset();
        req_ctrl = {4'b1101, 4'b0000};
        req_a = {32'h8000_0000, 32'd1};
        req_b = {32'd4, 32'd2};
        req_valid = 2'b10;
        rsp_ready = 2'b01;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_first_ready got %b exp 10", req_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_result !== 32'hF800_0000) begin errors++; $display("FAIL bp_sra_result got %h exp f8000000", rsp_result); end
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall_ready[%0d] got %b exp 00", i, req_ready); end
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL bp_stall_valid[%0d] got %b exp 10", i, rsp_valid); end
            checks++; if (rsp_result !== 32'hF800_0000) begin errors++; $display("FAIL bp_stall_result[%0d] got %h exp f8000000", i, rsp_result); end
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_release_ready got %b exp 01", req_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_release_valid got %b exp 01", rsp_valid); end
        checks++; if (rsp_result !== 32'd3) begin errors++; $display("FAIL bp_release_result got %h exp 3", rsp_result); end
        req_valid = 2'b00;
    endtask

    task automatic test_illegal_slt();
        do_reset();
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        req_ctrl[3:0] = 4'b1111;
        req_a[31:0] = 32'd1;
        req_b[31:0] = 32'd2;
        @(posedge clk); #1;
        checks++; if (rsp_result !== 32'h0 || rsp_zero !== 1'b1) begin errors++; $display("FAIL illegal_ctrl got %h/%b exp 0/1", rsp_result, rsp_zero); end
        req_ctrl[3:0] = 4'b0010;
        req_a[31:0] = 32'hFFFF_FFFF;
        req_b[31:0] = 32'd1;
        @(posedge clk); #1;
        checks++; if (rsp_result !== 32'd1 || rsp_zero !== 1'b0) begin errors++; $display("FAIL slt got %h/%b exp 1/0", rsp_result, rsp_zero); end
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL slt_valid got %b exp 01", rsp_valid); end
        req_valid = 2'b00;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_ctrl = {4'b0000, 4'b0000};
        req_a = {32'd3, 32'd10};
        req_b = {32'd4, 32'd20};
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd7) begin errors++; $display("FAIL ar_setup got %b/%h exp 10/7", rsp_valid, rsp_result); end
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL ar_valid_cleared got %b exp 00", rsp_valid); end
        checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL ar_result_cleared got %h exp 0", rsp_result); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL ar_ready_in_reset got %b exp 00", req_ready); end
        @(negedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ar_first_grant got %b exp 01", req_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd30) begin errors++; $display("FAIL ar_first_rsp got %b/%h exp 01/1e", rsp_valid, rsp_result); end
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_back_pressure();
        test_illegal_slt();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one combinational `alu` instance between `NUM_REQ` requesters, e.g. per-hart helper units in a multicore build. A round-robin grant selects one request per cycle and feeds it to the ALU. The result is captured in a single output register and returned on a shared result bus, with a one-hot per-requester valid. Throughput is one operation per cycle; back-pressure comes from the response side.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, NUM_REQ: request present, one bit per requester.
- `req_a`, in, NUM_REQ*32: operand A; requester i occupies bits [32i+31:32i].
- `req_b`, in, NUM_REQ*32: operand B; same packing as `req_a`.
- `req_ctrl`, in, NUM_REQ*4: ALU control code; requester i occupies bits [4i+3:4i].
- `req_ready`, out, NUM_REQ: request accepted this cycle; at most one bit set.
- `rsp_valid`, out, NUM_REQ: one-hot; result belongs to requester i.
- `rsp_result`, out, 32: registered ALU result.
- `rsp_zero`, out, 1: registered ALU zero flag.
- `rsp_ready`, in, NUM_REQ: requester i consumes its response.

## Operation
- `out_free` = !out_vld | (rsp_valid[id] & rsp_ready[id]).
- Grant is combinational over `req_valid`:
  - Search starts at the round-robin pointer `ptr` and wraps at NUM_REQ-1 to 0.
  - The first valid index wins.
- `req_ready[g]` = out_free & req_valid[g]. All other bits are 0. All bits are 0 when no request is valid.
- On acceptance (valid & ready for requester g):
  - Load `rsp_result` and `rsp_zero` from the ALU evaluated on g's operands.
  - Set out_vld=1 and out_id=g.
  - Set ptr = (g+1) mod NUM_REQ.
- Response is consumed without a new acceptance in the same cycle: out_vld goes to 0. `rsp_result` and `rsp_zero` keep their last values.
- Consume and accept in the same cycle: the register reloads. There is no bubble.
- Response not consumed: everything holds, all `req_ready` bits are 0, and ptr is frozen.
- Requesters hold valid and operands stable until accepted. The arbiter keeps no grant lock; the grant may move while the output is stalled.
- An illegal `req_ctrl` code passes through unchanged: result 0, zero 1.
- `rsp_ready` bits of non-owners are ignored.

## Timing
- Latency: accepted in cycle N, so `rsp_valid` is high in cycle N+1.
- Sustained rate is 1 op/cycle while the owner holds `rsp_ready` high.
- Combinational paths:
  - `req_valid` → `req_ready`.
  - `rsp_ready` → `req_ready`.
  - There is no path from `req_*` to `rsp_*`.
- Reset values:
  - `rsp_valid` = 0 (all bits).
  - `rsp_result` = 0.
  - `rsp_zero` = 0.
  - ptr = 0, out_id = 0.
  - `req_ready` reads 0 while `rst_n` is low.
- Reset asserted mid-operation: the pending response is dropped and not replayed. The first grant after reset release goes to the lowest valid index.

## Configuration
- With `ALU_ARB_RR_EN` defined: round-robin with rotating `ptr` as above.
- Without it: fixed priority, lowest valid index wins. ptr is not implemented; the search always starts at 0.
- All other behaviour is identical in both builds.

## Structure
- Package `alu_pkg` holds:
  - ALU control localparams: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - Data width 32 and control width 4.
- Sub-module `rr_arbiter`, parameterised by NUM_REQ: takes a request vector, a pointer and an advance strobe; produces a one-hot grant and the encoded index.
- The existing `alu` is instantiated once. The operand mux is built from the encoded index.

## Test plan
- **Single request.** Requester 0 sends ADD, 5 and 7; `rsp_ready` tied high. → `req_ready[0]` is 1 in cycle N. In N+1: `rsp_valid`=01, `rsp_result`=12, `rsp_zero`=0.
- **Both requesters valid continuously, `rsp_ready` high (RR build).** Requester 0 sends SUB 9,9; requester 1 sends OR 0xF0,0x0F. → Grants alternate 0,1,0,1. Responses alternate result 0 with zero 1, and 0xFF with zero 0. One per cycle, no gaps.
- **Same stimulus without `ALU_ARB_RR_EN`.** → Requester 0 is granted every cycle. `req_ready[1]` stays 0 until requester 0 drops valid.
- **Back-pressure.** Hold `rsp_ready[1]`=0 for 3 cycles while owning an SRA result (0x80000000 >>> 4 = 0xF8000000). → Result is held stable, all `req_ready`=0, ptr frozen. The cycle `rsp_ready` rises, the next grant is accepted with no bubble.
- **Illegal control and SLT.** Send ctrl 1111, then SLT with a=−1, b=1. → Responses are 0 with zero 1, then 1 with zero 0.
- **Async reset mid-stall.** Pulse `rst_n` low while `rsp_valid`=10. → `rsp_valid`=0 and `rsp_result`=0 immediately, without waiting for a clock edge. After release, the lowest valid index is granted first.
